input_normalizer: RTL and testbench

Upstream feeder for the fixed-point inference core. Accepts a stream of raw signed 32-bit samples and applies a per-feature min-max normalization (offset, scale, arithmetic shift) to 16-bit signed fixed point. Packs two consecutive features into the 32-bit `input_2_V` word. Drives the core's `ap_start`/`ap_ready`/`ap_done` block-level handshake, one inference per pair.

---
 rtl/nn_io_pkg.sv | 17 +
 rtl/input_normalizer_norm_lane.sv | 99 +++++++++
 rtl/input_normalizer.sv | 133 +++++++++++++
 tb/tb_input_normalizer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_io_pkg.sv
// Shared types and constants for the inference-core input path.
package nn_io_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned RAW_W  = 32;

  // Clamp limits for 16-bit signed fixed point
  localparam logic signed [DATA_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [DATA_W-1:0] SAT_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    StCollect,
    StIssue,
    StWait
  } state_e;

endpackage

// File: rtl/input_normalizer_norm_lane.sv
// norm_lane: 3-stage offset / multiply / shift datapath, time-shared between
// the two features of a pair. The feature index k rides along with valid and
// selects the offset in S1 and the scale in S2.
// Optional clamping controlled by INPUT_NORMALIZER_SAT_EN.
module norm_lane
  import nn_io_pkg::*;
#(
  parameter logic signed [RAW_W-1:0] OFFSET0 = 32'sd0,
  parameter logic signed [RAW_W-1:0] OFFSET1 = 32'sd0,
  parameter logic [17:0]             SCALE0  = 18'd16384,
  parameter logic [17:0]             SCALE1  = 18'd16384,
  parameter int unsigned             SHIFT   = 14
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              in_valid,
  input  logic              in_k,
  input  logic [RAW_W-1:0]  in_data,
  output logic              out_valid,
  output logic              out_k,
  output logic [DATA_W-1:0] out_res,
  output logic              out_sat
);

  logic signed [32:0] sum_d, s1_sum;
  logic               s1_valid, s1_k;
  logic signed [51:0] prod_d, s2_prod;
  logic               s2_valid, s2_k;
  logic signed [51:0] shifted;
  logic [DATA_W-1:0]  res_d;
  logic               sat_d;
  logic [RAW_W-1:0]   off_sel;
  logic [17:0]        scale_sel;

  // S1: sign-extend both operands to 33 bits so the add cannot overflow
  always_comb begin
    off_sel = in_k ? OFFSET1 : OFFSET0;
    sum_d   = $signed({in_data[RAW_W-1], in_data}) + $signed({off_sel[RAW_W-1], off_sel});
  end

  // S2: scale is unsigned, so zero-extend it before the signed multiply
  always_comb begin
    scale_sel = s1_k ? SCALE1 : SCALE0;
    prod_d    = $signed({{19{s1_sum[32]}}, s1_sum}) * $signed({34'd0, scale_sel});
  end

  // S3: arithmetic shift (floor), then reduce to 16 bits
  always_comb begin
    shifted = s2_prod >>> SHIFT;
`ifdef INPUT_NORMALIZER_SAT_EN
    res_d = shifted[DATA_W-1:0];
    sat_d = 1'b0;
    if (shifted > $signed({{36{SAT_MAX[DATA_W-1]}}, SAT_MAX})) begin
      res_d = SAT_MAX;
      sat_d = 1'b1;
    end else if (shifted < $signed({{36{SAT_MIN[DATA_W-1]}}, SAT_MIN})) begin
      res_d = SAT_MIN;
      sat_d = 1'b1;
    end
`else
    res_d = shifted[DATA_W-1:0];
    sat_d = 1'b0;
`endif
  end

`ifndef INPUT_NORMALIZER_SAT_EN
  // Upper bits are dropped in wrap mode
  logic unused_shift_hi;
  assign unused_shift_hi = ^shifted[51:DATA_W];
`endif

  // Pipeline registers; only the valid bits matter on reset
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s1_valid  <= 1'b0;
      s1_k      <= 1'b0;
      s1_sum    <= '0;
      s2_valid  <= 1'b0;
      s2_k      <= 1'b0;
      s2_prod   <= '0;
      out_valid <= 1'b0;
      out_k     <= 1'b0;
      out_res   <= '0;
      out_sat   <= 1'b0;
    end else begin
      s1_valid  <= in_valid;
      s1_k      <= in_k;
      s1_sum    <= sum_d;
      s2_valid  <= s1_valid;
      s2_k      <= s1_k;
      s2_prod   <= prod_d;
      out_valid <= s2_valid;
      out_k     <= s2_k;
      out_res   <= res_d;
      out_sat   <= sat_d;
    end
  end

endmodule

// File: rtl/input_normalizer.sv
// input_normalizer: normalizes pairs of raw samples into {feat1, feat0} and
// hands each pair to the inference core via ap_start/ap_ready/ap_done.
// Define INPUT_NORMALIZER_SAT_EN to clamp out-of-range results and drive
// sat_flag; otherwise results wrap and sat_flag stays 0.
module input_normalizer
  import nn_io_pkg::*;
#(
  parameter logic signed [RAW_W-1:0] OFFSET0 = 32'sd0,
  parameter logic signed [RAW_W-1:0] OFFSET1 = 32'sd0,
  parameter logic [17:0]             SCALE0  = 18'd16384,
  parameter logic [17:0]             SCALE1  = 18'd16384,
  parameter int unsigned             SHIFT   = 14
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic [RAW_W-1:0]   s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic               ap_start,
  input  logic               ap_ready,
  input  logic               ap_done,
  output logic [2*DATA_W-1:0] input_2_V,
  output logic               input_2_V_ap_vld,
  output logic               busy,
  output logic               sat_flag,
  output logic [15:0]        frame_cnt
);

  state_e            state_q, state_d;
  logic [1:0]        acc_cnt_q;
  logic              accept;
  logic              frame_inc;
  logic              lane_valid, lane_k, lane_sat;
  logic [DATA_W-1:0] lane_res;
  logic [2*DATA_W-1:0] word_q;
  logic              sat_q;
  logic [15:0]       frame_q;

  assign accept = s_valid && s_ready;

  norm_lane #(
    .OFFSET0 (OFFSET0),
    .OFFSET1 (OFFSET1),
    .SCALE0  (SCALE0),
    .SCALE1  (SCALE1),
    .SHIFT   (SHIFT)
  ) u_lane (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .in_valid  (accept),
    .in_k      (acc_cnt_q[0]),
    .in_data   (s_data),
    .out_valid (lane_valid),
    .out_k     (lane_k),
    .out_res   (lane_res),
    .out_sat   (lane_sat)
  );

  // FSM state register
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= StCollect;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; a completed inference bumps frame_cnt
  always_comb begin
    state_d   = state_q;
    frame_inc = 1'b0;
    unique case (state_q)
      StCollect: begin
        if (lane_valid && lane_k) state_d = StIssue;
      end
      StIssue: begin
        if (ap_ready) begin
          if (ap_done) begin
            state_d   = StCollect;
            frame_inc = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (ap_done) begin
          state_d   = StCollect;
          frame_inc = 1'b1;
        end
      end
      default: state_d = StCollect;
    endcase
  end

  // FSM outputs
  always_comb begin
    s_ready          = (state_q == StCollect) && !acc_cnt_q[1];
    ap_start         = (state_q == StIssue);
    input_2_V_ap_vld = (state_q == StIssue);
    busy             = !((state_q == StCollect) && (acc_cnt_q == 2'd0));
  end

  // Accepted-sample count; cleared outside COLLECT so each pair starts fresh
  always_ff @(posedge ap_clk) begin
    if (ap_rst || (state_q != StCollect)) begin
      acc_cnt_q <= 2'd0;
    end else if (accept) begin
      acc_cnt_q <= acc_cnt_q + 2'd1;
    end
  end

  // Result word, sticky saturation flag and inference counter
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      word_q  <= '0;
      sat_q   <= 1'b0;
      frame_q <= 16'd0;
    end else begin
      if (lane_valid) begin
        if (lane_k) word_q[2*DATA_W-1:DATA_W] <= lane_res;
        else        word_q[DATA_W-1:0]        <= lane_res;
        if (lane_sat) sat_q <= 1'b1;
      end
      if (frame_inc) frame_q <= frame_q + 16'd1;
    end
  end

  assign input_2_V = word_q;
  assign sat_flag  = sat_q;
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_input_normalizer.sv
// Scoreboard bench for input_normalizer: the driver pushes expected words
// computed with plain integer arithmetic, a monitor pops them on ap_start.
module tb_input_normalizer;

  localparam logic signed [31:0] OFF0 = 32'sd0;
  localparam logic signed [31:0] OFF1 = -32'sd256;
  localparam logic [17:0]        SC0  = 18'd16384;
  localparam logic [17:0]        SC1  = 18'd8192;
  localparam int unsigned        SH   = 14;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        ap_start;
  logic        ap_ready;
  logic        ap_done;
  logic [31:0] input_2_V;
  logic        input_2_V_ap_vld;
  logic        busy;
  logic        sat_flag;
  logic [15:0] frame_cnt;

  input_normalizer #(
    .OFFSET0 (OFF0),
    .OFFSET1 (OFF1),
    .SCALE0  (SC0),
    .SCALE1  (SC1),
    .SHIFT   (SH)
  ) dut (
    .ap_clk           (ap_clk),
    .ap_rst           (ap_rst),
    .s_data           (s_data),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .ap_start         (ap_start),
    .ap_ready         (ap_ready),
    .ap_done          (ap_done),
    .input_2_V        (input_2_V),
    .input_2_V_ap_vld (input_2_V_ap_vld),
    .busy             (busy),
    .sat_flag         (sat_flag),
    .frame_cnt        (frame_cnt)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [31:0] word;
    logic        sat;
    int          start_cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic        sat_model = 1'b0;
  logic [15:0] frame_model = 16'd0;
  logic        start_prev = 1'b0;
  logic [31:0] held_word = '0;

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: floor((raw + offset) * scale / 2^SH), then wrap or clamp
  function automatic logic [15:0] ref_feat(input logic [31:0] raw, input bit k,
                                           output bit sat);
    longint v;
    logic [15:0] r;
    v = longint'($signed(raw)) + (k ? longint'(OFF1) : longint'(OFF0));
    v = v * (k ? longint'(SC1) : longint'(SC0));
    v = v >>> SH;
    r   = v[15:0];
    sat = 1'b0;
`ifdef INPUT_NORMALIZER_SAT_EN
    if (v > 32767) begin
      r   = 16'h7FFF;
      sat = 1'b1;
    end else if (v < -32768) begin
      r   = 16'h8000;
      sat = 1'b1;
    end
`endif
    return r;
  endfunction

  // Monitor: on each new ap_start pop one expectation; while held, data must not move
  always @(negedge ap_clk) begin
    if (ap_rst) begin
      start_prev <= 1'b0;
    end else begin
      if (ap_start && !start_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_start", 32'(ap_start), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("word", input_2_V, mon_e.word);
          chk("start_latency", cyc, mon_e.start_cyc);
          chk("sat_flag", 32'(sat_flag), 32'(mon_e.sat));
          chk("vld_at_start", 32'(input_2_V_ap_vld), 32'd1);
        end
        held_word <= input_2_V;
      end else if (ap_start) begin
        chk("hold_word", input_2_V, held_word);
        chk("hold_vld", 32'(input_2_V_ap_vld), 32'd1);
      end
      start_prev <= ap_start;
    end
  end

  task automatic send_sample(input logic [31:0] x, output int acc);
    int guard;
    guard = 0;
    acc   = -1;
    while (acc < 0 && guard < 60) begin
      @(negedge ap_clk);
      if (s_ready) begin
        s_data  = x;
        s_valid = 1'b1;
        acc     = cyc;
        @(posedge ap_clk);
        #1;
        s_valid = 1'b0;
      end
      guard++;
    end
    if (acc < 0) chk("accept_timeout", 32'(s_ready), 32'd1);
  endtask

  task automatic send_pair(input logic [31:0] a, input logic [31:0] b);
    int   acc0, acc1;
    bit   sa, sb;
    exp_t e;
    logic [15:0] f0, f1;
    send_sample(a, acc0);
    send_sample(b, acc1);
    f0 = ref_feat(a, 1'b0, sa);
    f1 = ref_feat(b, 1'b1, sb);
    sat_model = sat_model | sa | sb;
    e.word      = {f1, f0};
    e.sat       = sat_model;
    e.start_cyc = acc1 + 4;
    exp_q.push_back(e);
  endtask

  task automatic wait_start(output bit ok);
    int guard;
    ok    = 1'b0;
    guard = 0;
    while (!ok && guard < 40) begin
      @(negedge ap_clk);
      if (ap_start) ok = 1'b1;
      guard++;
    end
    if (!ok) chk("start_timeout", 32'(ap_start), 32'd1);
  endtask

  // Core model: hold ap_ready low rdy_wait cycles, then either ready+done
  // together or done done_wait cycles after ready
  task automatic respond(input int rdy_wait, input int done_wait, input bit simul);
    bit ok;
    wait_start(ok);
    if (ok) begin
      repeat (rdy_wait) @(negedge ap_clk);
      if (rdy_wait > 0) begin
        chk("start_held", 32'(ap_start), 32'd1);
        chk("vld_held", 32'(input_2_V_ap_vld), 32'd1);
      end
      ap_ready = 1'b1;
      ap_done  = simul;
      @(negedge ap_clk);
      ap_ready = 1'b0;
      ap_done  = 1'b0;
      if (simul) begin
        frame_model++;
        chk("simul_frame_cnt", 32'(frame_cnt), 32'(frame_model));
        chk("simul_start_low", 32'(ap_start), 32'd0);
        chk("simul_s_ready", 32'(s_ready), 32'd1);
      end else begin
        chk("wait_start_low", 32'(ap_start), 32'd0);
        chk("wait_s_ready", 32'(s_ready), 32'd0);
        repeat (done_wait - 1) @(negedge ap_clk);
        ap_done = 1'b1;
        @(negedge ap_clk);
        ap_done = 1'b0;
        frame_model++;
        chk("frame_cnt", 32'(frame_cnt), 32'(frame_model));
        chk("s_ready_back", 32'(s_ready), 32'd1);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    logic [31:0] a, b;
    ap_rst   = 1'b1;
    s_data   = '0;
    s_valid  = 1'b0;
    ap_ready = 1'b0;
    ap_done  = 1'b0;

    // Reset values
    repeat (2) @(negedge ap_clk);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_ap_start", 32'(ap_start), 32'd0);
    chk("rst_vld", 32'(input_2_V_ap_vld), 32'd0);
    chk("rst_word", input_2_V, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sat", 32'(sat_flag), 32'd0);
    chk("rst_frame", 32'(frame_cnt), 32'd0);
    ap_rst = 1'b0;

    // Normalize and pack, then a slow ready and delayed done
    send_pair(32'd100, 32'h0000_0200);
    wait_start(ok);
    chk("pack_const", input_2_V, 32'h0080_0064);
    respond(5, 3, 1'b0);
    chk("frame_one", 32'(frame_cnt), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    // Saturation / wrap of an extreme pair
    send_pair(32'h7FFF_FFFF, 32'hFFFF_63C0);
    wait_start(ok);
`ifdef INPUT_NORMALIZER_SAT_EN
    chk("sat_word", input_2_V, 32'hB160_7FFF);
    chk("sat_flag_set", 32'(sat_flag), 32'd1);
`else
    chk("wrap_word", input_2_V, 32'hB160_FFFF);
    chk("sat_flag_tied", 32'(sat_flag), 32'd0);
`endif
    respond(0, 2, 1'b0);

    // ap_done while collecting must be ignored
    @(negedge ap_clk);
    ap_done = 1'b1;
    @(negedge ap_clk);
    ap_done = 1'b0;
    chk("done_in_collect", 32'(frame_cnt), 32'(frame_model));
    chk("done_in_collect_ready", 32'(s_ready), 32'd1);

    // Simultaneous ready and done in ISSUE
    send_pair(32'd12345, 32'hFFFF_F000);
    respond(1, 1, 1'b1);

    // Busy after one accepted sample of a pair
    begin
      int acc;
      send_sample(32'd7, acc);
      @(negedge ap_clk);
      chk("busy_half_pair", 32'(busy), 32'd1);
      chk("ready_half_pair", 32'(s_ready), 32'd1);
      b = 32'd900;
      send_sample(b, acc);
      exp_q.push_back('{word: {ref_feat(b, 1'b1, ok), ref_feat(32'd7, 1'b0, ok)},
                        sat: sat_model, start_cyc: acc + 4});
      respond(0, 1, 1'b0);
    end

    // Reset during WAIT
    send_pair(32'd55, 32'd66);
    wait_start(ok);
    ap_ready = 1'b1;
    @(negedge ap_clk);
    ap_ready = 1'b0;
    chk("in_wait_start_low", 32'(ap_start), 32'd0);
    ap_rst = 1'b1;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    exp_q.delete();
    frame_model = 16'd0;
    sat_model   = 1'b0;
    chk("midrst_start", 32'(ap_start), 32'd0);
    chk("midrst_frame", 32'(frame_cnt), 32'd0);
    chk("midrst_ready", 32'(s_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_sat", 32'(sat_flag), 32'd0);
    send_pair(32'hFFFF_FF00, 32'd1000);
    respond(2, 2, 1'b0);

    // Randomized pairs and core timing
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 2 == 1) begin
        a = {{17{a[14]}}, a[14:0]};
        b = {{17{b[14]}}, b[14:0]};
      end
      send_pair(a, b);
      respond(int'($urandom_range(3, 0)), int'($urandom_range(4, 1)),
              bit'($urandom_range(1, 0)));
    end

    repeat (4) @(negedge ap_clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("final_frame", 32'(frame_cnt), 32'(frame_model));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
